obstacle_manager: RTL and testbench



---
 rtl/obstacle_manager_pkg.sv | 33 +++
 rtl/obstacle_manager_lfsr16.sv | 26 ++
 rtl/obstacle_manager.sv | 204 ++++++++++++++++++++
 tb/tb_obstacle_manager.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/obstacle_manager_pkg.sv
// Shared obstacle record format and constants for the obstacle slot engine.
// Optional score counting in obstacle_manager is enabled by OBSTACLE_MGR_SCORE_EN.
package obstacle_manager_pkg;

    localparam int POSITION_WIDTH = 11;
    localparam int LANE_COUNT     = 3;

    localparam logic [1:0] OBSTACLE_TYPE_LOW  = 2'd0;
    localparam logic [1:0] OBSTACLE_TYPE_HIGH = 2'd1;

    typedef struct packed {
        logic [1:0]                obstacle_type;
        logic [POSITION_WIDTH-1:0] position;
        logic [1:0]                lane;
        logic                      active;
    } obstacle_t;

    typedef struct packed {
        logic [1:0]  fsm_state;
        logic [15:0] lfsr;
    } mgr_debug_t;

    // Fibonacci LFSR, taps 16,14,13,11.
    function automatic logic [15:0] lfsr16_next(input logic [15:0] v);
        return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
    endfunction

    // Only lanes 0..2 exist; the spare random code folds onto the centre lane.
    function automatic logic [1:0] lane_from_random(input logic [1:0] r);
        return (int'(r) >= LANE_COUNT) ? 2'd1 : r;
    endfunction

endpackage

// File: rtl/obstacle_manager_lfsr16.sv
// Free-running 16-bit Fibonacci LFSR used as the obstacle spawn randomness source.
module lfsr16
    import obstacle_manager_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    output logic [15:0] value_o
);

    logic [15:0] lfsr_q;
    logic [15:0] lfsr_d;

    assign lfsr_d  = lfsr16_next(lfsr_q);
    assign value_o = lfsr_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            lfsr_q <= SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

endmodule

// File: rtl/obstacle_manager.sv
// Obstacle slot engine: per-frame scroll/retire/collide sweep followed by LFSR spawning.
// Define OBSTACLE_MGR_SCORE_EN to build the saturating passed-obstacle score counter.
module obstacle_manager
    import obstacle_manager_pkg::*;
#(
    parameter int          NUM_OBSTACLES  = 10,
    parameter int          SPEED_WIDTH    = 3,
    parameter int          SPAWN_POS      = 1023,
    parameter int          SPAWN_INTERVAL = 60,
    parameter int          HIT_DEPTH      = 32,
    parameter logic [15:0] LFSR_SEED      = 16'hACE1,
    parameter int          SCORE_WIDTH    = 16
) (
    input  logic                              system_clock_in,
    input  logic                              reset_in,
    input  logic                              run_in,
    input  logic                              frame_tick_in,
    input  logic [SPEED_WIDTH-1:0]            speed_in,
    input  logic [1:0]                        player_lane_in,
    input  logic                              jump_in,
    output obstacle_t [NUM_OBSTACLES-1:0]     obstacles_out,
    output logic                              busy_out,
    output logic                              frame_done_out,
    output logic                              collision_out,
    output logic [SCORE_WIDTH-1:0]            score_out,
    output mgr_debug_t                        debug_out
);

    localparam int IDX_W = $clog2(NUM_OBSTACLES);
    localparam int CNT_W = $clog2(SPAWN_INTERVAL + 1);
    localparam logic [IDX_W-1:0]          LAST_IDX    = IDX_W'(NUM_OBSTACLES - 1);
    localparam logic [CNT_W-1:0]          CNT_RELOAD  = CNT_W'(SPAWN_INTERVAL);
    localparam logic [POSITION_WIDTH-1:0] SPAWN_POS_L = POSITION_WIDTH'(SPAWN_POS);
    localparam logic [POSITION_WIDTH:0]   HIT_LIMIT   = (POSITION_WIDTH + 1)'(HIT_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SWEEP = 2'd1,
        S_SPAWN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                         state_q;
    obstacle_t [NUM_OBSTACLES-1:0]  slots_q;
    logic [IDX_W-1:0]               idx_q;
    logic [SPEED_WIDTH-1:0]         speed_q;
    logic [1:0]                     lane_q;
    logic                           jump_q;
    logic [CNT_W-1:0]               count_q;
    logic                           busy_q;
    logic                           done_q;
    logic                           coll_q;

    logic [15:0]                    lfsr_value;
    logic [POSITION_WIDTH-1:0]      speed_ext;
    obstacle_t                      cur_slot;
    obstacle_t                      next_slot;
    obstacle_t                      spawn_slot;
    logic                           hit;
    logic                           free_found;
    logic [IDX_W-1:0]               free_idx;

    lfsr16 #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .clk_i   (system_clock_in),
        .rst_i   (reset_in),
        .value_o (lfsr_value)
    );

    assign speed_ext = POSITION_WIDTH'(speed_q);
    assign cur_slot  = slots_q[idx_q];

    // Hit check wins over retirement: a colliding slot is deactivated but not scored.
    always_comb begin
        next_slot = cur_slot;
        hit       = 1'b0;
        if (cur_slot.active) begin
            if ((cur_slot.lane == lane_q) &&
                ({1'b0, cur_slot.position} < HIT_LIMIT) &&
                !((cur_slot.obstacle_type == OBSTACLE_TYPE_LOW) && jump_q)) begin
                hit              = 1'b1;
                next_slot.active = 1'b0;
            end else if (cur_slot.position <= speed_ext) begin
                next_slot = '0;
            end else begin
                next_slot.position = cur_slot.position - speed_ext;
            end
        end
    end

    // Descending scan leaves the lowest-index free slot selected.
    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        for (int i = NUM_OBSTACLES - 1; i >= 0; i--) begin
            if (!slots_q[i].active) begin
                free_found = 1'b1;
                free_idx   = IDX_W'(i);
            end
        end
    end

    always_comb begin
        spawn_slot.obstacle_type = lfsr_value[2] ? OBSTACLE_TYPE_HIGH : OBSTACLE_TYPE_LOW;
        spawn_slot.position      = SPAWN_POS_L;
        spawn_slot.lane          = lane_from_random(lfsr_value[1:0]);
        spawn_slot.active        = 1'b1;
    end

    always_ff @(posedge system_clock_in) begin
        if (reset_in) begin
            state_q <= S_IDLE;
            slots_q <= '0;
            idx_q   <= '0;
            speed_q <= '0;
            lane_q  <= '0;
            jump_q  <= 1'b0;
            count_q <= CNT_RELOAD;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            coll_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            coll_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (frame_tick_in && run_in) begin
                        speed_q <= speed_in;
                        lane_q  <= player_lane_in;
                        jump_q  <= jump_in;
                        idx_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= S_SWEEP;
                    end
                end
                S_SWEEP: begin
                    slots_q[idx_q] <= next_slot;
                    coll_q         <= hit;
                    if (idx_q == LAST_IDX) begin
                        state_q <= S_SPAWN;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                S_SPAWN: begin
                    if (count_q == CNT_W'(1)) begin
                        count_q <= CNT_RELOAD;
                        if (free_found) begin
                            slots_q[free_idx] <= spawn_slot;
                        end
                    end else begin
                        count_q <= count_q - 1'b1;
                    end
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    state_q <= S_DONE;
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

`ifdef OBSTACLE_MGR_SCORE_EN
    logic [SCORE_WIDTH-1:0] score_q;
    logic [SCORE_WIDTH-1:0] score_d;
    logic                   retire;

    assign retire = (state_q == S_SWEEP) && cur_slot.active && !hit &&
                    (cur_slot.position <= speed_ext);

    always_comb begin
        score_d = score_q;
        if (retire && (score_q != {SCORE_WIDTH{1'b1}})) begin
            score_d = score_q + 1'b1;
        end
    end

    always_ff @(posedge system_clock_in) begin
        if (reset_in) begin
            score_q <= '0;
        end else begin
            score_q <= score_d;
        end
    end

    assign score_out = score_q;
`else
    assign score_out = '0;
`endif

    assign obstacles_out       = slots_q;
    assign busy_out            = busy_q;
    assign frame_done_out      = done_q;
    assign collision_out       = coll_q;
    assign debug_out.fsm_state = 2'(state_q);
    assign debug_out.lfsr      = lfsr_value;

endmodule

// File: tb/tb_obstacle_manager.sv
// Self-checking bench for obstacle_manager: tick-handling vector table, randomized
// frames against a slot-level reference model, and a mid-sweep reset sequence.
module tb_obstacle_manager;
    import obstacle_manager_pkg::*;

    localparam int          N          = 10;
    localparam int          SW         = 3;
    localparam int          SPOS       = 60;
    localparam int          SINT       = 2;
    localparam int          HIT        = 32;
    localparam logic [15:0] SEED       = 16'hACE1;
    localparam int          SCW        = 16;

    logic                   clk = 1'b0;
    logic                   reset_in = 1'b1;
    logic                   run_in = 1'b0;
    logic                   frame_tick_in = 1'b0;
    logic [SW-1:0]          speed_in = '0;
    logic [1:0]             player_lane_in = '0;
    logic                   jump_in = 1'b0;
    obstacle_t [N-1:0]      obstacles_out;
    logic                   busy_out;
    logic                   frame_done_out;
    logic                   collision_out;
    logic [SCW-1:0]         score_out;
    mgr_debug_t             debug_out;

    int checks = 0;
    int errors = 0;

    // reference model state
    int          m_type [N];
    int          m_pos  [N];
    int          m_lane [N];
    bit          m_act  [N];
    int          m_cnt;
    int          m_score;
    logic [15:0] m_lfsr;

    obstacle_manager #(
        .NUM_OBSTACLES  (N),
        .SPEED_WIDTH    (SW),
        .SPAWN_POS      (SPOS),
        .SPAWN_INTERVAL (SINT),
        .HIT_DEPTH      (HIT),
        .LFSR_SEED      (SEED),
        .SCORE_WIDTH    (SCW)
    ) dut (
        .system_clock_in (clk),
        .reset_in        (reset_in),
        .run_in          (run_in),
        .frame_tick_in   (frame_tick_in),
        .speed_in        (speed_in),
        .player_lane_in  (player_lane_in),
        .jump_in         (jump_in),
        .obstacles_out   (obstacles_out),
        .busy_out        (busy_out),
        .frame_done_out  (frame_done_out),
        .collision_out   (collision_out),
        .score_out       (score_out),
        .debug_out       (debug_out)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] ref_lfsr_step(input logic [15:0] v);
        logic fb;
        fb = v[15] ^ v[13] ^ v[12] ^ v[10];
        return {v[14:0], fb};
    endfunction

    always @(posedge clk) begin
        if (reset_in) m_lfsr <= SEED;
        else          m_lfsr <= ref_lfsr_step(m_lfsr);
    end

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_type[i] = 0; m_pos[i] = 0; m_lane[i] = 0; m_act[i] = 0;
        end
        m_cnt   = SINT;
        m_score = 0;
    endtask

    task automatic model_frame(input int spd, input int pl, input bit jmp,
                               input logic [15:0] lf, output int coll);
        int ln;
        coll = 0;
        for (int i = 0; i < N; i++) begin
            if (m_act[i]) begin
                if (m_lane[i] == pl && m_pos[i] < HIT && !(m_type[i] == 0 && jmp)) begin
                    m_act[i] = 0;
                    coll++;
                end else if (m_pos[i] <= spd) begin
                    m_type[i] = 0; m_pos[i] = 0; m_lane[i] = 0; m_act[i] = 0;
                    if (m_score < (1 << SCW) - 1) m_score++;
                end else begin
                    m_pos[i] = m_pos[i] - spd;
                end
            end
        end
        m_cnt--;
        if (m_cnt == 0) begin
            m_cnt = SINT;
            for (int i = 0; i < N; i++) begin
                if (!m_act[i]) begin
                    m_type[i] = int'(lf[2]);
                    m_pos[i]  = SPOS;
                    ln        = int'(lf[1:0]);
                    m_lane[i] = (ln == 3) ? 1 : ln;
                    m_act[i]  = 1;
                    break;
                end
            end
        end
    endtask

    task automatic check_slots(input string tag);
        logic [15:0] e;
        logic [15:0] a;
        for (int i = 0; i < N; i++) begin
            e = {2'(m_type[i]), 11'(m_pos[i]), 2'(m_lane[i]), m_act[i]};
            a = obstacles_out[i];
            check($sformatf("%s slot%0d", tag, i), a, e);
        end
`ifdef OBSTACLE_MGR_SCORE_EN
        check({tag, " score"}, score_out, m_score);
`else
        check({tag, " score"}, score_out, 0);
`endif
    endtask

    // Drive one tick, watch a fixed window, then compare against the model.
    task automatic do_frame(input string tag, input bit run, input int spd, input int pl,
                            input bit jmp, input int gap, input int exp_dones);
        logic [15:0] lf;
        int coll_seen, dones, done_at, exp_coll;
        coll_seen = 0; dones = 0; done_at = -1; exp_coll = 0;
        @(negedge clk);
        run_in = run; speed_in = SW'(spd); player_lane_in = 2'(pl); jump_in = jmp;
        frame_tick_in = 1'b1;
        lf = m_lfsr;
        for (int s = 0; s < N + 1; s++) lf = ref_lfsr_step(lf);
        for (int k = 1; k <= N + 6; k++) begin
            @(negedge clk);
            frame_tick_in = (k == gap);
            if (collision_out) coll_seen++;
            if (frame_done_out) begin
                dones++;
                if (done_at < 0) done_at = k;
            end
        end
        frame_tick_in = 1'b0;
        if (run) model_frame(spd, pl, jmp, lf, exp_coll);
        check({tag, " done_count"}, dones, exp_dones);
        if (exp_dones > 0) check({tag, " done_latency"}, done_at, N + 2);
        check({tag, " collisions"}, coll_seen, exp_coll);
        check({tag, " busy_idle"}, busy_out, 0);
        check_slots(tag);
    endtask

    typedef struct {
        bit run;
        int gap;
        int exp_dones;
    } tick_vec_t;

    tick_vec_t vecs[5];

    initial begin
        int dones;
        vecs[0] = '{run: 1'b1, gap: 0,     exp_dones: 1};
        vecs[1] = '{run: 1'b1, gap: 3,     exp_dones: 1};
        vecs[2] = '{run: 1'b1, gap: N + 1, exp_dones: 1};
        vecs[3] = '{run: 1'b1, gap: N + 2, exp_dones: 1};
        vecs[4] = '{run: 1'b0, gap: 0,     exp_dones: 0};

        model_reset();
        reset_in = 1'b1;
        repeat (3) @(negedge clk);
        reset_in = 1'b0;
        check("reset busy", busy_out, 0);
        check("reset done", frame_done_out, 0);
        check("reset collision", collision_out, 0);
        check("reset lfsr", debug_out.lfsr, SEED);
        check_slots("reset");

        for (int v = 0; v < 5; v++) begin
            do_frame($sformatf("vec%0d", v), vecs[v].run, 0, 0, 1'b0,
                     vecs[v].gap, vecs[v].exp_dones);
        end

        // speed 0 fills every slot, then spawns must be dropped
        for (int f = 0; f < 24; f++) begin
            do_frame($sformatf("fill%0d", f), 1'b1, 0, 0, 1'b0, 0, 1);
        end

        for (int f = 0; f < 40; f++) begin
            do_frame($sformatf("rand%0d", f), 1'b1, $urandom_range(0, 7),
                     $urandom_range(0, 2), 1'($urandom_range(0, 1)), 0, 1);
        end

        // reset while slot 4 is being processed
        @(negedge clk);
        run_in = 1'b1; speed_in = 3'd2; frame_tick_in = 1'b1;
        @(negedge clk);
        frame_tick_in = 1'b0;
        repeat (4) @(negedge clk);
        reset_in = 1'b1;
        @(negedge clk);
        reset_in = 1'b0;
        model_reset();
        check("midreset busy", busy_out, 0);
        check("midreset done", frame_done_out, 0);
        check("midreset lfsr", debug_out.lfsr, m_lfsr);
        check_slots("midreset");
        dones = 0;
        for (int k = 0; k < N + 6; k++) begin
            @(negedge clk);
            if (frame_done_out) dones++;
        end
        check("midreset no_done", dones, 0);

        for (int f = 0; f < 8; f++) begin
            do_frame($sformatf("post%0d", f), 1'b1, $urandom_range(0, 7),
                     $urandom_range(0, 2), 1'($urandom_range(0, 1)), 0, 1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
